// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and opcode in, result, flags and handshake out.
interface seq_alu_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;
  logic             flag_v;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi, flag_z, flag_c, flag_n, flag_v, illegal
  );

endinterface

// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with start/busy/done handshake and status flags.
// Define SEQ_ALU_MUL_EN to enable opcode 8 as a WIDTH-cycle shift-add unsigned multiplier.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam int         CNT_W   = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             w_busy;
  logic             w_load;
  logic             w_start_mul;
  logic             w_exec_wr;
  logic             w_mul_wr;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;

  logic [WIDTH-1:0] r_result;
  logic             r_z;
  logic             r_c;
  logic             r_n;
  logic             r_v;
  logic             r_ill;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] r_result_hi;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH:0]   w_part;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_last;

  // Low half of the accumulator starts as b and is shifted out LSB first.
  assign w_part      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_hi_next   = w_part[WIDTH:1];
  assign w_lo_next   = {w_part[0], r_acc_lo[WIDTH-1:1]};
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_start_mul = (bus.op == OP_MUL);
`else
  assign w_start_mul = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = w_start_mul ? S_MULT : S_EXEC;
        end
      end
      S_EXEC: w_state_next = S_IDLE;
`ifdef SEQ_ALU_MUL_EN
      S_MULT: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_load    = (r_state == S_IDLE) && bus.start;
    w_exec_wr = (r_state == S_EXEC);
`ifdef SEQ_ALU_MUL_EN
    w_mul_wr  = (r_state == S_MULT) && w_last;
`else
    w_mul_wr  = 1'b0;
`endif
  end

  // The extra top bit of the (WIDTH+1)-bit difference is set exactly when a < b.
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (r_op)
      OP_PASS: w_res = r_a;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_res = r_a & r_b;
      OP_OR:   w_res = r_a | r_b;
      OP_XOR:  w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res = {r_a[WIDTH-2:0], 1'b0};
        w_c   = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, r_a[WIDTH-1:1]};
        w_c   = r_a[0];
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_ill    <= 1'b0;
      r_done   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      r_result_hi <= '0;
      r_cnt       <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_a  <= bus.a;
        r_b  <= bus.b;
        r_op <= bus.op;
      end
      if (w_exec_wr) begin
        r_result <= w_res;
        r_z      <= (w_res == '0);
        r_c      <= w_c;
        r_n      <= w_res[WIDTH-1];
        r_v      <= w_v;
        r_ill    <= w_ill;
        r_done   <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
        r_result_hi <= '0;
`endif
      end
`ifdef SEQ_ALU_MUL_EN
      if (w_load) begin
        r_acc_hi <= '0;
        r_acc_lo <= bus.b;
        r_cnt    <= '0;
      end else if (r_state == S_MULT) begin
        r_acc_hi <= w_hi_next;
        r_acc_lo <= w_lo_next;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      if (w_mul_wr) begin
        r_result    <= w_lo_next;
        r_result_hi <= w_hi_next;
        r_z         <= (w_lo_next == '0);
        r_c         <= |w_hi_next;
        r_n         <= w_lo_next[WIDTH-1];
        r_v         <= 1'b0;
        r_ill       <= 1'b0;
        r_done      <= 1'b1;
      end
`endif
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.flag_z  = r_z;
  assign bus.flag_c  = r_c;
  assign bus.flag_n  = r_n;
  assign bus.flag_v  = r_v;
  assign bus.illegal = r_ill;
`ifdef SEQ_ALU_MUL_EN
  assign bus.result_hi = r_result_hi;
`else
  assign bus.result_hi = '0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed table, random ops vs. an arithmetic model, handshake corner cases.
module tb_seq_alu;

  localparam int W = 8;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] flags;  // {z, c, n, v, illegal}
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input logic [7:0] hi,
                              input logic [4:0] flags, input int lat);
    vec_t e;
    e.op = op; e.a = a; e.b = b; e.res = res; e.hi = hi; e.flags = flags; e.lat = lat;
    return e;
  endfunction

  // Reference model using plain integer arithmetic on unsigned and signed views of the operands.
  function automatic vec_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    vec_t e;
    int ua, ub, sa, sb, r, hi, lo;
    bit c, v, ill;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r = 0; hi = 0; c = 0; v = 0; ill = 0;
    e.lat = 1;
    case (op)
      4'd0: r = ua;
      4'd1: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd2: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6: begin r = ua * 2; c = (ua >= 128); end
      4'd7: begin r = ua / 2; c = (ua % 2) == 1; end
      4'd8: begin
        if (MUL_ON) begin
          r = ua * ub; hi = r / 256; c = (hi != 0); e.lat = W;
        end else begin
          ill = 1;
        end
      end
      default: ill = 1;
    endcase
    if (ill) r = 0;
    lo = r & 255;
    e.op = op; e.a = a; e.b = b;
    e.res = 8'(lo);
    e.hi = 8'(hi);
    e.flags = {lo == 0, c, lo >= 128, v, ill};
    return e;
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done) chk({tag, ".busy_mid"}, bus.busy, 1);
    end while (!bus.done && lat < 40);
    if (!bus.done) begin
      n_chk++; n_fail++;
      $display("FAIL %s.timeout: got no done, expected done within 40 cycles", tag);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, ".result"}, bus.result, e.res);
    chk({tag, ".result_hi"}, bus.result_hi, e.hi);
    chk({tag, ".flags_zcnvi"}, {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v, bus.illegal}, e.flags);
  endtask

  task automatic run_vec(input string tag, input vec_t e);
    int lat;
    start_op(e.op, e.a, e.b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy_accept"}, bus.busy, 1);
    chk({tag, ".done_accept"}, bus.done, 0);
    wait_done(tag, lat);
    chk({tag, ".latency"}, lat, e.lat);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    check_outputs(tag, e);
    $display("txn %s op=%0h a=%02h b=%02h -> result=%02h hi=%02h zcnvi=%05b lat=%0d",
             tag, e.op, e.a, e.b, bus.result, bus.result_hi,
             {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v, bus.illegal}, lat);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".hold"}, bus.result, e.res);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".result"}, bus.result, 0);
    chk({tag, ".result_hi"}, bus.result_hi, 0);
    chk({tag, ".flags_zcnvi"}, {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v, bus.illegal}, 0);
  endtask

  vec_t tbl [14];

  initial begin
    int   lat;
    vec_t e;
    logic [3:0] op;

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mk(4'h1, 8'hFF, 8'h01, 8'h00, 8'h00, 5'b11000, 1);
    tbl[1]  = mk(4'h2, 8'h80, 8'h01, 8'h7F, 8'h00, 5'b00010, 1);
    tbl[2]  = mk(4'h2, 8'h00, 8'h01, 8'hFF, 8'h00, 5'b01100, 1);
    tbl[3]  = mk(4'h6, 8'h81, 8'h00, 8'h02, 8'h00, 5'b01000, 1);
    tbl[4]  = mk(4'h7, 8'h81, 8'h00, 8'h40, 8'h00, 5'b01000, 1);
    tbl[5]  = mk(4'h3, 8'hF0, 8'h3C, 8'h30, 8'h00, 5'b00000, 1);
    tbl[6]  = mk(4'h4, 8'hF0, 8'h0F, 8'hFF, 8'h00, 5'b00100, 1);
    tbl[7]  = mk(4'h5, 8'hAA, 8'hAA, 8'h00, 8'h00, 5'b10000, 1);
    tbl[8]  = mk(4'h1, 8'h7F, 8'h01, 8'h80, 8'h00, 5'b00110, 1);
    tbl[9]  = mk(4'h0, 8'h00, 8'h77, 8'h00, 8'h00, 5'b10000, 1);
    tbl[10] = mk(4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 5'b10001, 1);
    tbl[11] = mk(4'h0, 8'h5A, 8'h00, 8'h5A, 8'h00, 5'b00000, 1);
`ifdef SEQ_ALU_MUL_EN
    tbl[12] = mk(4'h8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 5'b01000, 8);
    tbl[13] = mk(4'h8, 8'h0F, 8'h11, 8'hFF, 8'h00, 5'b00100, 8);
`else
    tbl[12] = mk(4'h8, 8'hFF, 8'hFF, 8'h00, 8'h00, 5'b10001, 1);
    tbl[13] = mk(4'h8, 8'h0F, 8'h11, 8'h00, 8'h00, 5'b10001, 1);
`endif

    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(9, 15));
      else                           op = 4'($urandom_range(0, 8));
      run_vec($sformatf("rnd%0d", i), model(op, 8'($urandom), 8'($urandom)));
    end

    // start pulsed while busy must be dropped, not queued
    e = model(4'h8, 8'hFF, 8'hFF);
    start_op(4'h8, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h1; bus.a = 8'h01; bus.b = 8'h01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!bus.done) wait_done("ignore", lat);
    chk("ignore.done", bus.done, 1);
    check_outputs("ignore", e);
    @(posedge clk); #1;
    chk("ignore.no_second_done", bus.done, 0);
    chk("ignore.no_second_busy", bus.busy, 0);
    $display("txn ignore op=8 a=ff b=ff with ADD pulse -> result=%02h hi=%02h", bus.result, bus.result_hi);

    // start held through done is accepted on the next edge
    e = model(4'h8, 8'h0F, 8'h11);
    start_op(4'h8, 8'h0F, 8'h11);
    @(posedge clk); #1;
    bus.op = 4'h1; bus.a = 8'h01; bus.b = 8'h01;
    wait_done("b2b_first", lat);
    check_outputs("b2b_first", e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.busy_accept", bus.busy, 1);
    chk("b2b.done_accept", bus.done, 0);
    @(posedge clk); #1;
    chk("b2b.done", bus.done, 1);
    chk("b2b.result", bus.result, 8'h02);
    $display("txn b2b op=8 a=0f b=11 then ADD 01+01 -> result=%02h", bus.result);

    // reset in the middle of an op: everything clears and no done pulse follows
    start_op(4'h8, 8'hFF, 8'hFF);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (MUL_ON ? 3 : 0) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("midreset.no_done", bus.done, 0);
    end
    $display("txn midreset op=8 aborted -> result=%02h done=%0b", bus.result, bus.done);
    run_vec("post_reset_add", mk(4'h1, 8'h03, 8'h04, 8'h07, 8'h00, 5'b00000, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
